// File: rtl/iob_merge_rr.sv
// iob_merge_rr: round-robin merge of N_MASTERS IOb native masters onto one
// IOb native slave port. One transaction in flight; the owner is locked until
// the slave returns ready. Optional watchdog enabled by defining
// MERGE_TIMEOUT_EN (adds the err port and a TIMEOUT_W-bit counter).
module iob_merge_rr #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT_W = 16,
    localparam int REQ_W    = 1 + ADDR_W + DATA_W + DATA_W / 8,
    localparam int RESP_W   = DATA_W + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MASTERS*REQ_W-1:0]    m_req,
    output logic [N_MASTERS*RESP_W-1:0]   m_resp,
    output logic [REQ_W-1:0]              s_req,
    input  logic [RESP_W-1:0]             s_resp,
    output logic [N_MASTERS-1:0]          grant,
    output logic                          busy
`ifdef MERGE_TIMEOUT_EN
    ,
    output logic                          err
`endif
);

    localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    if (N_MASTERS < 1 || N_MASTERS > 8 || TIMEOUT_W < 2) begin : g_bad_cfg
        $error("iob_merge_rr: unsupported parameter combination");
    end

    logic [0:0]           state_q, state_d;
    logic [N_MASTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]     last_q, last_d;

    logic [N_MASTERS-1:0] m_valid;
    logic [IDX_W-1:0]     winner;
    logic                 any_valid;
    logic [REQ_W-1:0]     own_req;
    logic                 s_ready;
    logic                 tmo;
    logic [RESP_W-1:0]    own_resp;

`ifdef MERGE_TIMEOUT_EN
    localparam logic [DATA_W+31:0] TMO_RDATA_EXT = {{DATA_W{1'b0}}, 32'hDEADBEEF};
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
`endif

    assign s_ready = s_resp[0];

    // Collect the valid bit (MSB) of every master slice.
    always_comb begin
        m_valid = '0;
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            m_valid[i] = m_req[i*REQ_W + REQ_W - 1];
        end
    end

    // Round-robin search: first valid master starting after the last winner.
    always_comb begin
        int unsigned      cand;
        logic [IDX_W-1:0] cand_idx;
        winner    = last_q;
        any_valid = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned i = 1; i <= N_MASTERS; i++) begin
            cand     = (32'(last_q) + i) % N_MASTERS;
            cand_idx = cand[IDX_W-1:0];
            if (!any_valid && m_valid[cand_idx]) begin
                any_valid = 1'b1;
                winner    = cand_idx;
            end
        end
    end

    // Request slice of the current owner (last_q holds the owner while BUSY).
    always_comb begin
        own_req = '0;
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            if (last_q == IDX_W'(i)) begin
                own_req = m_req[i*REQ_W +: REQ_W];
            end
        end
    end

    // Watchdog expiry: only when the slave has not answered in this cycle.
`ifdef MERGE_TIMEOUT_EN
    assign tmo = (state_q == S_BUSY) && !s_ready && (cnt_q == '1);
    assign err = tmo;
`else
    assign tmo = 1'b0;
`endif

    // FSM next state, grant register and rotation pointer.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
`ifdef MERGE_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (any_valid) begin
                    state_d = S_BUSY;
                    last_d  = winner;
                    for (int unsigned i = 0; i < N_MASTERS; i++) begin
                        grant_d[i] = (winner == IDX_W'(i));
                    end
`ifdef MERGE_TIMEOUT_EN
                    cnt_d = '0;
`endif
                end
            end
            S_BUSY: begin
                if (s_ready || tmo) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                end else begin
`ifdef MERGE_TIMEOUT_EN
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Output muxing: everything is zero while idle.
    always_comb begin
        s_req    = '0;
        m_resp   = '0;
        own_resp = s_resp;
        if (state_q == S_BUSY) begin
            s_req = own_req;
`ifdef MERGE_TIMEOUT_EN
            if (tmo) begin
                s_req[REQ_W-1] = 1'b0;
                own_resp       = {TMO_RDATA_EXT[DATA_W-1:0], 1'b1};
            end
`endif
            for (int unsigned i = 0; i < N_MASTERS; i++) begin
                if (last_q == IDX_W'(i)) begin
                    m_resp[i*RESP_W +: RESP_W] = own_resp;
                end
            end
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q == S_BUSY);

    // State registers; pointer resets to the top master so master 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(N_MASTERS - 1);
`ifdef MERGE_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
`ifdef MERGE_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_iob_merge_rr.sv
// Scoreboard bench for iob_merge_rr (N_MASTERS=2, 32-bit address/data).
module tb_iob_merge_rr;
    localparam int N      = 2;
    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int REQ_W  = 1 + AW + DW + DW / 8;
    localparam int RESP_W = DW + 1;
`ifdef MERGE_TIMEOUT_EN
    localparam int TW = 4;
`else
    localparam int TW = 16;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N*REQ_W-1:0]     m_req;
    logic [N*RESP_W-1:0]    m_resp;
    logic [REQ_W-1:0]       s_req;
    logic [RESP_W-1:0]      s_resp;
    logic [N-1:0]           grant;
    logic                   busy;
`ifdef MERGE_TIMEOUT_EN
    logic                   err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    iob_merge_rr #(
        .N_MASTERS(N),
        .ADDR_W(AW),
        .DATA_W(DW),
        .TIMEOUT_W(TW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .m_req(m_req),
        .m_resp(m_resp),
        .s_req(s_req),
        .s_resp(s_resp),
        .grant(grant),
        .busy(busy)
`ifdef MERGE_TIMEOUT_EN
        ,
        .err(err)
`endif
    );

    typedef struct {
        int          m;
        logic [31:0] a;
        logic [31:0] w;
        logic [3:0]  s;
        logic [31:0] r;
        bit          tmo;
    } txn_t;

    typedef logic [N-1:0] g_t;

    txn_t        mq[$];     // requests waiting to be driven
    txn_t        eq[$];     // expected responses
    logic [31:0] smem [logic [31:0]];
    g_t          glog[$];
    g_t          eseq[$];
    int          idle_log[$];
    int          idle_run;
    g_t          prev_grant;
    logic [N-1:0] act;
    int          served[N];
    int          slave_lat  = 2;
    bit          slave_hang = 1'b0;
    int          scnt       = 0;

    task automatic chk(input string name, input logic [127:0] actv, input logic [127:0] expv);
        checks++;
        if (actv !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, actv, expv);
        end
    endtask

    task automatic req(input int m, input logic [31:0] a, input logic [31:0] w,
                       input logic [3:0] s, input logic [31:0] r, input bit tmo);
        txn_t t;
        t.m = m; t.a = a; t.w = w; t.s = s; t.r = r; t.tmo = tmo;
        if (!tmo) smem[a] = r;
        mq.push_back(t);
        eq.push_back(t);
    endtask

    task automatic chk_glog(input string name);
        chk({name, "_len"}, 128'(glog.size()), 128'(eseq.size()));
        for (int k = 0; k < eseq.size() && k < glog.size(); k++) begin
            chk($sformatf("%s_%0d", name, k), 128'(glog[k]), 128'(eseq[k]));
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((mq.size() > 0 || eq.size() > 0 || act != '0 || busy) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 1000) begin
            errors++;
            $display("FAIL %s: drain timeout, pending exp %0d required 0", name, eq.size());
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Slave model: answers after slave_lat extra cycles with smem contents.
    initial begin
        s_resp = '0;
        forever begin
            @(posedge clk);
            #1;
            s_resp = '0;
            if (rst) begin
                scnt = 0;
            end else if (s_req[REQ_W-1] && !slave_hang) begin
                if (scnt >= slave_lat) begin
                    s_resp = {(smem.exists(s_req[67:36]) ? smem[s_req[67:36]] : 32'h0), 1'b1};
                    scnt   = 0;
                end else begin
                    scnt++;
                end
            end else begin
                scnt = 0;
            end
        end
    end

    // Master models: hold a request until ready, then load the next one.
    initial begin
        m_req = '0;
        act   = '0;
        for (int i = 0; i < N; i++) served[i] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (act[i] && m_resp[i*RESP_W]) begin
                    act[i] = 1'b0;
                    served[i]++;
                end
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (!act[i]) begin
                    m_req[i*REQ_W + REQ_W - 1] = 1'b0;
                    for (int k = 0; k < mq.size(); k++) begin
                        if (mq[k].m == i) begin
                            m_req[i*REQ_W +: REQ_W] = {1'b1, mq[k].a, mq[k].w, mq[k].s};
                            mq.delete(k);
                            act[i] = 1'b1;
                            break;
                        end
                    end
                end
            end
        end
    end

    // Monitor: grant history, idle gaps, and scoreboard compare on every ready.
    initial begin
        prev_grant = '0;
        idle_run   = 0;
        forever begin
            @(negedge clk);
            if (grant !== prev_grant) begin
                glog.push_back(grant);
                prev_grant = grant;
            end
            if (!busy) begin
                idle_run++;
            end else if (idle_run > 0) begin
                idle_log.push_back(idle_run);
                idle_run = 0;
            end
            if (!rst) begin
                for (int i = 0; i < N; i++) begin
                    if (m_resp[i*RESP_W]) begin
                        int kk;
                        kk = -1;
                        for (int j = 0; j < eq.size(); j++) begin
                            if (eq[j].m == i) begin
                                kk = j;
                                break;
                            end
                        end
                        if (kk < 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_ready: master %0d got ready=1 required 0", i);
                        end else begin
                            chk($sformatf("rdata_m%0d", i), 128'(m_resp[i*RESP_W+1 +: DW]), 128'(eq[kk].r));
                            chk($sformatf("s_req_m%0d", i), 128'(s_req),
                                128'({~eq[kk].tmo, eq[kk].a, eq[kk].w, eq[kk].s}));
                            chk($sformatf("grant_at_ready_m%0d", i), 128'(grant), 128'(1) << i);
                            chk($sformatf("other_resp_m%0d", i), 128'(m_resp[(1-i)*RESP_W +: RESP_W]), 128'(0));
                            eq.delete(kk);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_grant", 128'(grant), 128'(0));
        chk("reset_busy", 128'(busy), 128'(0));
        chk("reset_s_req", 128'(s_req), 128'(0));
        chk("reset_m_resp", 128'(m_resp), 128'(0));
`ifdef MERGE_TIMEOUT_EN
        chk("reset_err", 128'(err), 128'(0));
`endif
        rst = 1'b0;

        // Single write from master 0.
        @(negedge clk);
        glog.delete();
        req(0, 32'h80000010, 32'h12345678, 4'hF, 32'h0, 1'b0);
        n = 0;
        while (!m_req[REQ_W-1] && n < 50) begin @(negedge clk); n++; end
        chk("t1_valid_seen", 128'(m_req[REQ_W-1]), 128'(1));
        chk("t1_s_req_idle", 128'(s_req), 128'(0));
        chk("t1_grant_idle", 128'(grant), 128'(0));
        @(negedge clk);
        chk("t1_s_req_lat1", 128'(s_req), 128'({1'b1, 32'h80000010, 32'h12345678, 4'hF}));
        chk("t1_grant_busy", 128'(grant), 128'(2'b01));
        wait_idle("t1");
        eseq = '{2'b01, 2'b00};
        chk_glog("t1_glog");
        chk("t1_m1_no_ready", 128'(served[1]), 128'(0));

        // Contention right after reset: master 0 must win.
        do_reset();
        @(negedge clk);
        glog.delete();
        req(0, 32'h00001000, 32'h0, 4'h0, 32'hAAAA0000, 1'b0);
        req(1, 32'h00002000, 32'h0, 4'h0, 32'h5555FFFF, 1'b0);
        wait_idle("t2");
        eseq = '{2'b01, 2'b00, 2'b10, 2'b00};
        chk_glog("t2_glog");

        // Fairness: both masters re-request continuously.
        glog.delete();
        for (int i = 0; i < N; i++) served[i] = 0;
        for (int k = 0; k < 4; k++) begin
            req(0, 32'h00003000 + 32'(k*4), 32'h0, 4'h0, 32'hF0000000 | 32'(k), 1'b0);
            req(1, 32'h00004000 + 32'(k*4), 32'h0, 4'h0, 32'h0F000000 | 32'(k), 1'b0);
        end
        wait_idle("t3");
        eseq.delete();
        for (int k = 0; k < 8; k++) begin
            eseq.push_back((k % 2 == 0) ? 2'b01 : 2'b10);
            eseq.push_back(2'b00);
        end
        chk_glog("t3_glog");
        chk("t3_served_m0", 128'(served[0]), 128'(4));
        chk("t3_served_m1", 128'(served[1]), 128'(4));

        // Back-to-back owner: master 1 alone, three reads.
        glog.delete();
        idle_log.delete();
        for (int k = 0; k < 3; k++) begin
            req(1, 32'h00005000 + 32'(k*4), 32'h0, 4'h0, 32'hB0B00000 | 32'(k), 1'b0);
        end
        wait_idle("t4");
        eseq = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00};
        chk_glog("t4_glog");
        chk("t4_gap1", 128'((idle_log.size() > 1) ? idle_log[1] : -1), 128'(1));
        chk("t4_gap2", 128'((idle_log.size() > 2) ? idle_log[2] : -1), 128'(1));

        // Reset in the 2nd BUSY cycle of a master 0 read, master 1 pending.
        slave_lat = 6;
        glog.delete();
        req(0, 32'h00006000, 32'h0, 4'h0, 32'h11112222, 1'b0);
        n = 0;
        while (!busy && n < 50) begin @(negedge clk); n++; end
        chk("t5_busy_seen", 128'(busy), 128'(1));
        req(1, 32'h00007000, 32'h0, 4'h0, 32'h33334444, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t5_rst_grant", 128'(grant), 128'(0));
        chk("t5_rst_busy", 128'(busy), 128'(0));
        chk("t5_rst_s_req", 128'(s_req), 128'(0));
        chk("t5_rst_m_resp", 128'(m_resp), 128'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wait_idle("t5");
        eseq = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        chk_glog("t5_glog");
        slave_lat = 2;

`ifdef MERGE_TIMEOUT_EN
        // Watchdog: slave never answers.
        slave_hang = 1'b1;
        req(0, 32'h00009000, 32'h0, 4'h0, 32'hDEADBEEF, 1'b1);
        n = 0;
        while (!busy && n < 50) begin @(negedge clk); n++; end
        n = 0;
        while (!m_resp[0] && n < 100) begin
            chk("t6_no_err_early", 128'(err), 128'(0));
            n++;
            @(negedge clk);
        end
        chk("t6_busy_cycles", 128'(n), 128'(15));
        chk("t6_err_pulse", 128'(err), 128'(1));
        @(negedge clk);
        chk("t6_err_clear", 128'(err), 128'(0));
        chk("t6_idle_after", 128'(busy), 128'(0));
        slave_hang = 1'b0;
        wait_idle("t6");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
